tri_raster_sequencer: RTL and testbench

- Sequences one triangle at a time through three edge-function pipelines, one per edge.
- Per triangle: accept the three vertices, compute a screen-clamped bounding box, scan it row-major, and issue pixel coordinates to the three pipes under valid/ready.
- Joins the three isInside results and emits covered fragments downstream.
- Sits between the triangle-setup front end and the fragment/shading stage.

---
 rtl/raster_pkg.sv | 38 +++
 rtl/raster_bbox_clamp.sv | 73 +++++++
 rtl/tri_raster_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_tri_raster_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types for the triangle raster sequencer: coordinates, vertices,
// bounding boxes and the sequencer state encoding.
package raster_pkg;
  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vertex_t;

  typedef struct packed {
    coord_t min_x;
    coord_t max_x;
    coord_t min_y;
    coord_t max_y;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction
endpackage

// File: rtl/raster_bbox_clamp.sv
// Two-stage bounding box: stage 1 registers the signed min/max of the three
// vertices, stage 2 registers the screen-clamped box used for the scan.
module raster_bbox_clamp
  import raster_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stage1_en,
  input  logic                      stage2_en,
  input  logic signed [COORD_W-1:0] v0_x,
  input  logic signed [COORD_W-1:0] v0_y,
  input  logic signed [COORD_W-1:0] v1_x,
  input  logic signed [COORD_W-1:0] v1_y,
  input  logic signed [COORD_W-1:0] v2_x,
  input  logic signed [COORD_W-1:0] v2_y,
  output logic [COORD_W-1:0]        nxt_min_x,
  output logic [COORD_W-1:0]        nxt_min_y,
  output logic                      nxt_empty,
  output logic [COORD_W-1:0]        box_min_x,
  output logic [COORD_W-1:0]        box_max_x,
  output logic [COORD_W-1:0]        box_min_y,
  output logic [COORD_W-1:0]        box_max_y
);
  localparam coord_t X_HI = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_HI = coord_t'(SCREEN_H - 1);

  vertex_t a, b, c;
  bbox_t   raw, clamped, box;

  assign a.x = v0_x;
  assign a.y = v0_y;
  assign b.x = v1_x;
  assign b.y = v1_y;
  assign c.x = v2_x;
  assign c.y = v2_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      raw <= '0;
      box <= '0;
    end else begin
      if (stage1_en) begin
        raw.min_x <= min3(a.x, b.x, c.x);
        raw.max_x <= max3(a.x, b.x, c.x);
        raw.min_y <= min3(a.y, b.y, c.y);
        raw.max_y <= max3(a.y, b.y, c.y);
      end
      if (stage2_en) box <= clamped;
    end
  end

  // Mins only clamp upward and maxes only downward, so a box lying wholly
  // off one side of the screen ends up with min > max and is seen as empty.
  always_comb begin
    clamped = raw;
    if (raw.min_x < 0)    clamped.min_x = '0;
    if (raw.min_y < 0)    clamped.min_y = '0;
    if (raw.max_x > X_HI) clamped.max_x = X_HI;
    if (raw.max_y > Y_HI) clamped.max_y = Y_HI;
  end

  assign nxt_empty = (clamped.min_x > clamped.max_x) || (clamped.min_y > clamped.max_y);
  assign nxt_min_x = clamped.min_x;
  assign nxt_min_y = clamped.min_y;

  assign box_min_x = box.min_x;
  assign box_max_x = box.max_x;
  assign box_min_y = box.min_y;
  assign box_max_y = box.max_y;
endmodule

// File: rtl/tri_raster_sequencer.sv
// Triangle raster sequencer: bbox scan issue to three edge pipes plus result join.
// Optional back-face culling of non-positive-area triangles: RASTER_BACKFACE_CULL_EN.
//
// state | meaning
// IDLE  | waiting for a triangle, tri_ready high
// SETUP | two cycles: bbox min/max, then screen clamp and empty/cull decision
// SCAN  | issuing bbox pixels row-major under the outstanding credit limit
// DRAIN | waiting for in-flight results to return, then pulse tri_done
module tri_raster_sequencer
  import raster_pkg::*;
#(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic signed [10:0] v0_x,
  input  logic signed [10:0] v0_y,
  input  logic signed [10:0] v1_x,
  input  logic signed [10:0] v1_y,
  input  logic signed [10:0] v2_x,
  input  logic signed [10:0] v2_y,
  output logic signed [10:0] e_v0_x,
  output logic signed [10:0] e_v0_y,
  output logic signed [10:0] e_v1_x,
  output logic signed [10:0] e_v1_y,
  output logic signed [10:0] e_v2_x,
  output logic signed [10:0] e_v2_y,
  output logic               ef_valid,
  input  logic [2:0]         ef_ready,
  output logic [10:0]        ef_pixel_x,
  output logic [10:0]        ef_pixel_y,
  input  logic [2:0]         res_valid,
  input  logic [2:0]         res_inside,
  input  logic [10:0]        res_pixel_x,
  input  logic [10:0]        res_pixel_y,
  output logic               res_ready,
  output logic               frag_valid,
  input  logic               frag_ready,
  output logic [10:0]        frag_x,
  output logic [10:0]        frag_y,
  output logic               tri_done,
  output logic               busy
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_t             state;
  logic               setup_phase;
  logic [CNT_W-1:0]   outstanding;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic [COORD_W-1:0] nxt_min_x, nxt_min_y;
  logic               nxt_empty;
  logic [COORD_W-1:0] box_min_x, box_max_x, box_min_y, box_max_y;
  logic               stage1_en, stage2_en;
  logic               all_v, all_in, fire, consume;
  logic               cull;

  assign stage1_en = (state == SETUP) && !setup_phase;
  assign stage2_en = (state == SETUP) && setup_phase;

  raster_bbox_clamp #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_bbox (
    .clk       (clk),
    .reset     (reset),
    .stage1_en (stage1_en),
    .stage2_en (stage2_en),
    .v0_x      (e_v0_x),
    .v0_y      (e_v0_y),
    .v1_x      (e_v1_x),
    .v1_y      (e_v1_y),
    .v2_x      (e_v2_x),
    .v2_y      (e_v2_y),
    .nxt_min_x (nxt_min_x),
    .nxt_min_y (nxt_min_y),
    .nxt_empty (nxt_empty),
    .box_min_x (box_min_x),
    .box_max_x (box_max_x),
    .box_min_y (box_min_y),
    .box_max_y (box_max_y)
  );

`ifdef RASTER_BACKFACE_CULL_EN
  logic signed [23:0] d1x, d1y, d2x, d2y, area2;

  assign d1x   = 24'(e_v1_x) - 24'(e_v0_x);
  assign d1y   = 24'(e_v1_y) - 24'(e_v0_y);
  assign d2x   = 24'(e_v2_x) - 24'(e_v0_x);
  assign d2y   = 24'(e_v2_y) - 24'(e_v0_y);
  assign area2 = d1x * d2y - d1y * d2x;

  always_ff @(posedge clk) begin
    if (reset)          cull <= 1'b0;
    else if (stage1_en) cull <= (area2 <= 0);
  end
`else
  assign cull = 1'b0;
`endif

  // Join: uncovered results drain immediately, covered ones wait for downstream.
  assign all_v      = &res_valid;
  assign all_in     = &res_inside;
  assign frag_valid = all_v & all_in;
  assign frag_x     = res_pixel_x;
  assign frag_y     = res_pixel_y;
  assign res_ready  = all_v & (~all_in | frag_ready);
  assign consume    = res_ready;

  assign ef_valid   = (state == SCAN) && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign fire       = ef_valid & (&ef_ready);
  assign ef_pixel_x = scan_x;
  assign ef_pixel_y = scan_y;
  assign tri_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      setup_phase <= 1'b0;
      tri_done    <= 1'b0;
      outstanding <= '0;
      scan_x      <= '0;
      scan_y      <= '0;
      e_v0_x      <= '0;
      e_v0_y      <= '0;
      e_v1_x      <= '0;
      e_v1_y      <= '0;
      e_v2_x      <= '0;
      e_v2_y      <= '0;
    end else begin
      tri_done    <= 1'b0;
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(consume);
      case (state)
        IDLE: begin
          if (tri_valid) begin
            e_v0_x      <= v0_x;
            e_v0_y      <= v0_y;
            e_v1_x      <= v1_x;
            e_v1_y      <= v1_y;
            e_v2_x      <= v2_x;
            e_v2_y      <= v2_y;
            setup_phase <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          setup_phase <= 1'b1;
          if (setup_phase) begin
            if (nxt_empty || cull) begin
              state <= DRAIN;
            end else begin
              scan_x <= nxt_min_x;
              scan_y <= nxt_min_y;
              state  <= SCAN;
            end
          end
        end
        SCAN: begin
          if (fire) begin
            if (scan_x == box_max_x) begin
              scan_x <= box_min_x;
              if (scan_y == box_max_y) state <= DRAIN;
              else                     scan_y <= scan_y + 1'b1;
            end else begin
              scan_x <= scan_x + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            tri_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_raster_sequencer.sv
// Directed bench for tri_raster_sequencer: models three lockstep edge pipes and
// checks issue order, covered fragments and drain behaviour per triangle.
`timescale 1ns/1ps
module tb_tri_raster_sequencer;
  localparam int LAT = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               tri_valid, tri_ready;
  logic signed [10:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
  logic signed [10:0] e_v0_x, e_v0_y, e_v1_x, e_v1_y, e_v2_x, e_v2_y;
  logic               ef_valid;
  logic [2:0]         ef_ready;
  logic [10:0]        ef_pixel_x, ef_pixel_y;
  logic [2:0]         res_valid, res_inside;
  logic [10:0]        res_pixel_x, res_pixel_y;
  logic               res_ready;
  logic               frag_valid, frag_ready;
  logic [10:0]        frag_x, frag_y;
  logic               tri_done, busy;

  always #5 clk = ~clk;

  tri_raster_sequencer dut (
    .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .e_v0_x(e_v0_x), .e_v0_y(e_v0_y), .e_v1_x(e_v1_x), .e_v1_y(e_v1_y),
    .e_v2_x(e_v2_x), .e_v2_y(e_v2_y),
    .ef_valid(ef_valid), .ef_ready(ef_ready), .ef_pixel_x(ef_pixel_x), .ef_pixel_y(ef_pixel_y),
    .res_valid(res_valid), .res_inside(res_inside), .res_pixel_x(res_pixel_x),
    .res_pixel_y(res_pixel_y), .res_ready(res_ready),
    .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y),
    .tri_done(tri_done), .busy(busy)
  );

  typedef struct {
    int v0x, v0y, v1x, v1y, v2x, v2y;
    int minx, maxx, miny, maxy;
    int n_iss, n_frag;
    int hold;
    bit stall;
    bit quick;
  } vec_t;

  typedef struct { int x; int y; logic [2:0] ins; int due; } ent_t;
  typedef struct { int x; int y; } pix_t;

  vec_t tbl[8];
  ent_t pipe_q[$];
  pix_t exp_iss[$];
  pix_t exp_frag[$];
  vec_t cur;
  int   total = 0, bad = 0, cyc = 0;
  int   n_iss, n_frag, n_done, acc_cyc, done_cyc, hold_left;
  bit   stall_on;

  function automatic int edge_fn(int ax, int ay, int bx, int by, int px, int py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic logic [2:0] inside_bits(vec_t v, int px, int py);
    logic [2:0] r;
    r[0] = edge_fn(v.v0x, v.v0y, v.v1x, v.v1y, px, py) >= 0;
    r[1] = edge_fn(v.v1x, v.v1y, v.v2x, v.v2y, px, py) >= 0;
    r[2] = edge_fn(v.v2x, v.v2y, v.v0x, v.v0y, px, py) >= 0;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_le(string name, int act, int lim);
    total++;
    if (act > lim || act < 0) begin
      bad++;
      $display("FAIL %s: got %0d expected 0..%0d", name, act, lim);
    end
  endtask

  task automatic tick();
    bit   f, c, a;
    int   px, py;
    pix_t e;
    @(negedge clk);
    f  = ef_valid && (&ef_ready);
    c  = res_ready;
    a  = tri_valid && tri_ready;
    px = int'(ef_pixel_x);
    py = int'(ef_pixel_y);
    if (f && !reset) begin
      n_iss++;
      if (exp_iss.size() == 0) chk("issue_extra", n_iss, 0);
      else begin
        e = exp_iss.pop_front();
        chk("issue_x", px, e.x);
        chk("issue_y", py, e.y);
      end
    end
    if (frag_valid && frag_ready && !reset) begin
      n_frag++;
      if (exp_frag.size() == 0) chk("frag_extra", n_frag, 0);
      else begin
        e = exp_frag.pop_front();
        chk("frag_x", int'(frag_x), e.x);
        chk("frag_y", int'(frag_y), e.y);
      end
    end
    if (res_valid != 3'b000 && res_valid != 3'b111) chk("mismatch_no_consume", int'(res_ready), 0);
    if (tri_done) begin
      n_done++;
      if (n_done == 1) done_cyc = cyc;
    end
    if (a) acc_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (a) tri_valid = 1'b0;
    if (reset) pipe_q.delete();
    else begin
      if (c && pipe_q.size() > 0) pipe_q.delete(0);
      if (f) pipe_q.push_back('{x: px, y: py, ins: inside_bits(cur, px, py), due: cyc + LAT});
    end
    if (hold_left > 0) begin
      frag_ready = 1'b0;
      hold_left--;
    end else begin
      frag_ready = stall_on ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    ef_ready    = (stall_on && $urandom_range(0, 3) == 0) ? 3'b101 : 3'b111;
    res_valid   = 3'b000;
    res_inside  = 3'b000;
    res_pixel_x = '0;
    res_pixel_y = '0;
    if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      res_valid   = 3'b111;
      res_inside  = pipe_q[0].ins;
      res_pixel_x = 11'(pipe_q[0].x);
      res_pixel_y = 11'(pipe_q[0].y);
      if (stall_on && $urandom_range(0, 4) == 0) res_valid = 3'b011;
    end
  endtask

  task automatic load_exp(vec_t v);
    exp_iss.delete();
    exp_frag.delete();
    for (int y = v.miny; y <= v.maxy; y++)
      for (int x = v.minx; x <= v.maxx; x++) begin
        exp_iss.push_back('{x: x, y: y});
        if (inside_bits(v, x, y) == 3'b111) exp_frag.push_back('{x: x, y: y});
      end
    n_iss = 0; n_frag = 0; n_done = 0; acc_cyc = -1; done_cyc = -1;
    cur = v; hold_left = v.hold; stall_on = v.stall;
  endtask

  task automatic start_tri(vec_t v);
    v0_x = 11'(v.v0x); v0_y = 11'(v.v0y);
    v1_x = 11'(v.v1x); v1_y = 11'(v.v1y);
    v2_x = 11'(v.v2x); v2_y = 11'(v.v2y);
    tri_valid = 1'b1;
  endtask

  task automatic run_vec(vec_t v);
    load_exp(v);
    start_tri(v);
    for (int i = 1; i <= 3000 && n_done == 0; i++) begin
      tick();
      if (v.hold > 0 && i == 40) begin
        chk("sat_outstanding", pipe_q.size(), 8);
        chk("sat_ef_valid", int'(ef_valid), 0);
      end
    end
    if (n_done == 0) chk("tri_done_timeout", n_done, 1);
    repeat (4) tick();
    chk("issues", n_iss, v.n_iss);
    chk("frags", n_frag, v.n_frag);
    chk("tri_done_pulses", n_done, 1);
    chk("exp_iss_left", exp_iss.size(), 0);
    chk("exp_frag_left", exp_frag.size(), 0);
    chk("pipes_empty", pipe_q.size(), 0);
    chk("busy_after", int'(busy), 0);
    if (v.quick) chk_le("done_latency", done_cyc - acc_cyc, 4);
  endtask

  initial begin
    reset = 1'b1; tri_valid = 1'b0;
    v0_x = '0; v0_y = '0; v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0;
    ef_ready = 3'b111; res_valid = '0; res_inside = '0;
    res_pixel_x = '0; res_pixel_y = '0; frag_ready = 1'b1;
    hold_left = 0; stall_on = 1'b0; n_iss = 0; n_frag = 0; n_done = 0;

    tbl[0] = '{2, 2, 6, 2, 2, 6,             2, 6, 2, 6,           25, 15,  0, 0, 0};
    tbl[1] = '{-5, -5, -1, -5, -5, -1,       1, 0, 1, 0,            0,  0,  0, 0, 1};
    tbl[2] = '{630, 470, 700, 470, 630, 500, 630, 639, 470, 479,  100, 100, 0, 0, 0};
    tbl[3] = '{2, 2, 6, 2, 2, 6,             2, 6, 2, 6,           25, 15, 50, 0, 0};
    tbl[4] = '{-3, -3, 4, -3, -3, 4,         0, 4, 0, 4,           25,  3,  0, 1, 0};
`ifdef RASTER_BACKFACE_CULL_EN
    tbl[5] = '{2, 2, 2, 6, 6, 2,             1, 0, 1, 0,            0,  0,  0, 0, 1};
    tbl[6] = '{10, 10, 10, 10, 10, 10,       1, 0, 1, 0,            0,  0,  0, 0, 1};
`else
    tbl[5] = '{2, 2, 2, 6, 6, 2,             2, 6, 2, 6,           25,  0,  0, 0, 0};
    tbl[6] = '{10, 10, 10, 10, 10, 10,       10, 10, 10, 10,        1,  1,  0, 0, 0};
`endif
    tbl[7] = '{700, 100, 800, 100, 700, 200, 1, 0, 1, 0,            0,  0,  0, 0, 1};

    repeat (3) tick();
    chk("rst_tri_ready", int'(tri_ready), 1);
    chk("rst_ef_valid", int'(ef_valid), 0);
    chk("rst_res_ready", int'(res_ready), 0);
    chk("rst_frag_valid", int'(frag_valid), 0);
    chk("rst_tri_done", int'(tri_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_e_v0_x", int'(e_v0_x), 0);
    chk("rst_e_v2_y", int'(e_v2_y), 0);
    chk("rst_pixel_x", int'(ef_pixel_x), 0);
    chk("rst_pixel_y", int'(ef_pixel_y), 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(tbl[k]);

    // Abandon a triangle mid-scan, then make sure the next one is clean.
    load_exp(tbl[0]);
    start_tri(tbl[0]);
    repeat (12) tick();
    chk("mid_scan_busy", int'(busy), 1);
    reset = 1'b1;
    repeat (2) tick();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_tri_ready", int'(tri_ready), 1);
    chk("mid_rst_ef_valid", int'(ef_valid), 0);
    reset = 1'b0;
    tick();
    run_vec(tbl[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
